// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Hazard and stall scheduler for a 5-stage RV32I pipeline. It sits beside
//   the control unit and handles four jobs:
//     - detects load-use hazards between the ID and EX stages
//     - generates the EX operand forwarding selects
//     - freezes the pipeline while a data-memory access waits on mem_ready,
//       and latches a sticky error if the access never completes
//     - merges branch-redirect flushes and counts stall cycles
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   id_rs1/2, id_use_rs1/2        source registers of the ID instr, and whether
//                                 each one is actually read
//   ex_rs1/2, ex_rd               EX instr source and destination registers
//   ex_regwen, ex_is_load         EX instr writes rd / is a load
//   mem_rd, mem_regwen, mem_is_load  MEM-stage writer info
//   wb_rd, wb_regwen              WB-stage writer info
//   mem_req, mem_ready            data-memory access handshake in MEM
//   br_redirect                   taken-branch/jump mispredict resolved in EX
//   pc_stall, if_id_stall         hold PC / hold IF/ID
//   id_ex_bubble                  load a NOP into ID/EX
//   pipe_freeze                   hold every pipeline register
//   if_flush, id_flush            squash the IF / ID instructions
//   fwd_a_sel, fwd_b_sel          00 regfile, 01 from WB, 10 from MEM
//   mem_timeout_err               sticky memory-timeout error
//   stall_count                   saturating count of cycles with pc_stall=1
module hazard_stall_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 15,
  parameter int unsigned CNT_WIDTH      = 4,
  parameter int unsigned PERF_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_regwen,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_regwen,
  input  logic                      mem_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_regwen,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      br_redirect,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      id_ex_bubble,
  output logic                      pipe_freeze,
  output logic                      if_flush,
  output logic                      id_flush,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic                      mem_timeout_err,
  output logic [PERF_WIDTH-1:0]     stall_count
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 freeze;
  logic                 load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Freeze is decided here alongside the next state. In MEM_WAIT it drops in
  // the cycle mem_ready arrives, so the pipeline advances on that same edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    freeze    = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_WIDTH'(1);
          freeze    = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          freeze = 1'b1;
          if (cnt == TIMEOUT_CNT) begin
            state_nxt = ERR;
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end
      end
      ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign mem_timeout_err = (state == ERR);
  assign pipe_freeze     = freeze;

  always_comb begin
    load_use = 1'b0;
    if (ex_is_load && ex_regwen && (ex_rd != '0)) begin
      load_use = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd));
    end
  end

  // Priority: freeze > redirect > load-use. A redirect seen during a freeze
  // is simply not acted on yet; EX is held so it stays asserted until the
  // freeze drops.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    if (freeze) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else if (br_redirect) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  // A load in MEM has no data yet, so it cannot be a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_regwen && (mem_rd != '0) && !mem_is_load && (mem_rd == rs)) begin
      sel = 2'b10;
    end else if (wb_regwen && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_sel = fwd_sel(ex_rs1);
    fwd_b_sel = fwd_sel(ex_rs2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (pc_stall && (stall_count != '1)) begin
      stall_count <= stall_count + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_regwen, ex_is_load;
  logic       mem_regwen, mem_is_load, wb_regwen;
  logic       mem_req, mem_ready, br_redirect;
  logic       pc_stall, if_id_stall, id_ex_bubble, pipe_freeze;
  logic       if_flush, id_flush, mem_timeout_err;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  hazard_stall_ctrl #(
    .REG_ADDR_WIDTH(5),
    .MEM_TIMEOUT(15),
    .CNT_WIDTH(4),
    .PERF_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwen(ex_regwen), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_regwen(mem_regwen), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_regwen(wb_regwen),
    .mem_req(mem_req), .mem_ready(mem_ready), .br_redirect(br_redirect),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
    .pipe_freeze(pipe_freeze), .if_flush(if_flush), .id_flush(id_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_timeout_err(mem_timeout_err), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwen = 0; ex_is_load = 0;
    mem_rd = '0; mem_regwen = 0; mem_is_load = 0;
    wb_rd = '0; wb_regwen = 0;
    mem_req = 0; mem_ready = 0; br_redirect = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // lw x5 in EX
  task automatic set_lw_x5();
    ex_is_load = 1; ex_regwen = 1; ex_rd = 5'd5;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL reset_pc_stall: got %b expected 0", pc_stall); end
    checks++; if (pipe_freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %b expected 0", pipe_freeze); end
    checks++; if (mem_timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", mem_timeout_err); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count); end
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b expected 0000", {fwd_a_sel, fwd_b_sel}); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    // lw x5 in EX, add x6,x5,x1 in ID
    set_lw_x5();
    id_rs1 = 5'd5; id_use_rs1 = 1; id_rs2 = 5'd1; id_use_rs2 = 1;
    #1;
    checks++; if ({pc_stall, if_id_stall, id_ex_bubble} !== 3'b111) begin errors++; $display("FAIL lu_stall: got %b expected 111", {pc_stall, if_id_stall, id_ex_bubble}); end
    checks++; if ({if_flush, id_flush, pipe_freeze} !== 3'b000) begin errors++; $display("FAIL lu_noflush: got %b expected 000", {if_flush, id_flush, pipe_freeze}); end
    // lw moves to MEM, bubble in EX, add still in ID
    @(negedge clk);
    ex_is_load = 0; ex_regwen = 0; ex_rd = '0;
    mem_rd = 5'd5; mem_regwen = 1; mem_is_load = 1;
    #1;
    checks++; if ({pc_stall, id_ex_bubble} !== 2'b00) begin errors++; $display("FAIL lu_one_cycle: got %b expected 00", {pc_stall, id_ex_bubble}); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", stall_count); end
    // lw in WB, bubble in MEM, add in EX
    @(negedge clk);
    mem_rd = '0; mem_regwen = 0; mem_is_load = 0;
    wb_rd = 5'd5; wb_regwen = 1;
    ex_rs1 = 5'd5; ex_rs2 = 5'd1; ex_rd = 5'd6; ex_regwen = 1;
    id_use_rs1 = 0; id_use_rs2 = 0;
    #1;
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL lu_fwd_a: got %b expected 01", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL lu_fwd_b: got %b expected 00", fwd_b_sel); end
  endtask

  task automatic test_no_stall();
    @(negedge clk);
    clear_inputs();
    set_lw_x5();
    id_rs1 = 5'd0; id_use_rs1 = 1; id_rs2 = 5'd1; id_use_rs2 = 1;
    #1;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL ns_rs1_x0: got %b expected 0", pc_stall); end
    id_rs1 = 5'd5; id_use_rs1 = 0;
    #1;
    checks++; if (id_ex_bubble !== 1'b0) begin errors++; $display("FAIL ns_unused_rs1: got %b expected 0", id_ex_bubble); end
    id_rs2 = 5'd5;
    #1;
    checks++; if (id_ex_bubble !== 1'b1) begin errors++; $display("FAIL ns_rs2_match: got %b expected 1", id_ex_bubble); end
    ex_rd = 5'd0; id_rs2 = 5'd0;
    #1;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL ns_load_x0: got %b expected 0", pc_stall); end
    ex_rd = 5'd5; id_rs2 = 5'd5; ex_regwen = 0;
    #1;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL ns_no_regwen: got %b expected 0", pc_stall); end
    ex_regwen = 1; ex_is_load = 0;
    #1;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL ns_not_load: got %b expected 0", pc_stall); end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    clear_inputs();
    set_lw_x5();
    id_rs1 = 5'd5; id_use_rs1 = 1;
    br_redirect = 1;
    #1;
    checks++; if ({if_flush, id_flush} !== 2'b11) begin errors++; $display("FAIL rd_flush: got %b expected 11", {if_flush, id_flush}); end
    checks++; if ({pc_stall, if_id_stall, id_ex_bubble} !== 3'b000) begin errors++; $display("FAIL rd_override: got %b expected 000", {pc_stall, if_id_stall, id_ex_bubble}); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1; mem_ready = 0; br_redirect = 1;
    set_lw_x5();
    id_rs1 = 5'd5; id_use_rs1 = 1;
    #1;
    checks++; if ({pipe_freeze, pc_stall, if_id_stall} !== 3'b111) begin errors++; $display("FAIL mw_freeze0: got %b expected 111", {pipe_freeze, pc_stall, if_id_stall}); end
    checks++; if ({id_ex_bubble, if_flush, id_flush} !== 3'b000) begin errors++; $display("FAIL mw_withheld0: got %b expected 000", {id_ex_bubble, if_flush, id_flush}); end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if ({pipe_freeze, if_flush} !== 2'b10) begin errors++; $display("FAIL mw_freeze%0d: got %b expected 10", i, {pipe_freeze, if_flush}); end
    end
    @(negedge clk);
    mem_ready = 1;
    #1;
    checks++; if (pipe_freeze !== 1'b0) begin errors++; $display("FAIL mw_release: got %b expected 0", pipe_freeze); end
    checks++; if ({if_flush, id_flush, pc_stall, id_ex_bubble} !== 4'b1100) begin errors++; $display("FAIL mw_late_flush: got %b expected 1100", {if_flush, id_flush, pc_stall, id_ex_bubble}); end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL mw_count: got %0d expected 3", stall_count); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (pipe_freeze !== 1'b0) begin errors++; $display("FAIL mw_back_run: got %b expected 0", pipe_freeze); end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL mw_count_hold: got %0d expected 3", stall_count); end
  endtask

  task automatic test_async_reset_wait();
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (2) @(negedge clk);
    mem_req = 0;
    #1;
    checks++; if (pipe_freeze !== 1'b1) begin errors++; $display("FAIL ar_in_wait: got %b expected 1", pipe_freeze); end
    rst_n = 0;
    #1;
    checks++; if ({pipe_freeze, stall_count} !== 17'd0) begin errors++; $display("FAIL ar_cleared: got %b/%0d expected 0/0", pipe_freeze, stall_count); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++; if (pipe_freeze !== 1'b0) begin errors++; $display("FAIL ar_run: got %b expected 0", pipe_freeze); end
  endtask

  task automatic test_timeout();
    int early_err;
    do_reset();
    mem_req = 1; mem_ready = 0;
    early_err = 0;
    // one RUN cycle plus 15 MEM_WAIT cycles stay error-free
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if ({mem_timeout_err, pipe_freeze} !== 2'b01) begin errors++; early_err++; $display("FAIL to_wait%0d: got %b expected 01", i, {mem_timeout_err, pipe_freeze}); end
      @(negedge clk);
    end
    #1;
    checks++; if ({mem_timeout_err, pipe_freeze} !== 2'b11) begin errors++; $display("FAIL to_err: got %b expected 11", {mem_timeout_err, pipe_freeze}); end
    checks++; if (stall_count !== 16'd16) begin errors++; $display("FAIL to_count: got %0d expected 16", stall_count); end
    mem_req = 0; mem_ready = 1;
    @(negedge clk);
    #1;
    checks++; if ({mem_timeout_err, pipe_freeze, id_ex_bubble} !== 3'b110) begin errors++; $display("FAIL to_sticky: got %b expected 110", {mem_timeout_err, pipe_freeze, id_ex_bubble}); end
    rst_n = 0;
    #1;
    checks++; if ({mem_timeout_err, pipe_freeze} !== 2'b00) begin errors++; $display("FAIL to_reset_clear: got %b expected 00", {mem_timeout_err, pipe_freeze}); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    clear_inputs();
    ex_rs1 = 5'd3; ex_rs2 = 5'd7;
    mem_rd = 5'd7; mem_regwen = 1;
    wb_rd = 5'd7; wb_regwen = 1;
    #1;
    checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL fw_mem_wins: got %b expected 10", fwd_b_sel); end
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL fw_a_none: got %b expected 00", fwd_a_sel); end
    mem_is_load = 1;
    #1;
    checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL fw_mem_load: got %b expected 01", fwd_b_sel); end
    mem_is_load = 0; mem_regwen = 0;
    #1;
    checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL fw_mem_noregwen: got %b expected 01", fwd_b_sel); end
    wb_regwen = 0;
    #1;
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL fw_none: got %b expected 00", fwd_b_sel); end
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; mem_rd = 5'd0; mem_regwen = 1; wb_rd = 5'd0; wb_regwen = 1;
    #1;
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL fw_x0: got %b expected 0000", {fwd_a_sel, fwd_b_sel}); end
    ex_rs1 = 5'd9; mem_rd = 5'd4; wb_rd = 5'd9;
    #1;
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL fw_a_wb: got %b expected 01", fwd_a_sel); end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_req = 1; mem_ready = 0;
    // ERR holds pc_stall high, so the counter runs into its ceiling
    repeat (65540) @(negedge clk);
    #1;
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count: got %h expected ffff", stall_count); end
    @(negedge clk);
    #1;
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_no_wrap: got %h expected ffff", stall_count); end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect();
    test_mem_wait();
    test_async_reset_wait();
    test_timeout();
    test_forwarding();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
